// File: rtl/systolic_writeback.sv
// systolic_writeback
// Takes one accumulator row per cycle from the systolic array, requantises every
// lane to OUT_WIDTH with round-half-up and signed saturation, and writes the row to
// the result SRAM through a small FIFO that absorbs SRAM backpressure.
// wb_done pulses once the job's last row has reached the SRAM.
// Optional build macro: WB_RELU_EN (negative lanes are clamped to zero before saturation).
//
// Handshake: sram_ready is a per-cycle grant from the SRAM. A row is popped from the
// FIFO in any cycle where the FIFO holds data and sram_ready=1; that row appears on
// sram_addr/sram_wdata with sram_wen=1 in the following cycle. sram_wen never
// depends combinationally on sram_ready.
module systolic_writeback #(
   parameter int ARRAY_SIZE = 16,
   parameter int ACC_WIDTH  = 18,
   parameter int OUT_WIDTH  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            srst,
   input  logic                            tpu_start,
   input  logic                            tpu_done,
   input  logic                            wr_valid,
   input  logic [5:0]                      matrix_index,
   input  logic [1:0]                      data_set,
   input  logic [ARRAY_SIZE*ACC_WIDTH-1:0] acc_row,
   input  logic [4:0]                      shift,
   input  logic                            sram_ready,
   output logic                            sram_wen,
   output logic [7:0]                      sram_addr,
   output logic [ARRAY_SIZE*OUT_WIDTH-1:0] sram_wdata,
   output logic                            overflow,
   output logic [15:0]                     sat_cnt,
   output logic                            wb_done
);

   localparam int ROW_OUT_W = ARRAY_SIZE * OUT_WIDTH;
   localparam int ENTRY_W   = 8 + ROW_OUT_W;
   localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W     = $clog2(ARRAY_SIZE + 1);

   localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'((2**(OUT_WIDTH-1)) - 1);
   localparam logic signed [ACC_WIDTH:0] SAT_MIN = (ACC_WIDTH+1)'(-(2**(OUT_WIDTH-1)));

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_DONE = 2'd2
   } done_state_t;

   // Done FSM state, kept as a named enum so checkers can bind to it directly.
   done_state_t state, state_next;

   logic [ROW_OUT_W-1:0] rq_row;
   logic [CNT_W-1:0]     rq_clips;
   logic [16:0]          sat_sum;

   logic                 st_valid;
   logic [ENTRY_W-1:0]   st_entry;

   logic [ENTRY_W-1:0]   fifo_mem [FIFO_DEPTH];
   logic [PTR_W:0]       wr_ptr, rd_ptr;
   logic                 fifo_empty, fifo_full;
   logic                 pop, push, stall;

   // Requantise the incoming row lane by lane and count clipped lanes.
   always_comb begin : requant
      logic signed [ACC_WIDTH:0] rnd;
      logic signed [ACC_WIDTH:0] t;
      logic signed [ACC_WIDTH:0] s;
      rq_row   = '0;
      rq_clips = '0;
      rnd      = '0;
      t        = '0;
      s        = '0;
      for (int i = 0; i < ARRAY_SIZE; i++) begin
         // Rounding constant is half an output LSB; zero when no shift is applied.
         rnd = (shift == 5'd0) ? '0 : ((ACC_WIDTH+1)'(1) << (shift - 5'd1));
         t   = $signed({acc_row[i*ACC_WIDTH + ACC_WIDTH - 1], acc_row[i*ACC_WIDTH +: ACC_WIDTH]}) + rnd;
         s   = t >>> shift;
`ifdef WB_RELU_EN
         // A clamp to zero is intended behaviour, not a saturation event.
         if (s < 0) begin
            s = '0;
         end else if (s > SAT_MAX) begin
            s        = SAT_MAX;
            rq_clips = rq_clips + CNT_W'(1);
         end
`else
         if (s > SAT_MAX) begin
            s        = SAT_MAX;
            rq_clips = rq_clips + CNT_W'(1);
         end else if (s < SAT_MIN) begin
            s        = SAT_MIN;
            rq_clips = rq_clips + CNT_W'(1);
         end
`endif
         rq_row[i*OUT_WIDTH +: OUT_WIDTH] = s[OUT_WIDTH-1:0];
      end
      sat_sum = {1'b0, sat_cnt} + 17'(rq_clips);
   end

   // FIFO status and the stage-to-FIFO move. When the FIFO is full and nothing
   // leaves it, the stage register holds its row and a new incoming row is dropped.
   always_comb begin
      fifo_empty = (wr_ptr == rd_ptr);
      fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
      pop        = !fifo_empty && sram_ready;
      stall      = st_valid && fifo_full && !pop;
      push       = st_valid && !stall;
   end

   // Stage register: captures the requantised row unless it is stalled.
   always_ff @(posedge clk) begin
      if (srst) begin
         st_valid <= 1'b0;
         st_entry <= '0;
      end else if (wr_valid && !stall) begin
         st_valid <= 1'b1;
         st_entry <= {data_set, matrix_index, rq_row};
      end else if (push) begin
         st_valid <= 1'b0;
      end
   end

   // Job flags: sticky overflow on a dropped row, saturating clip counter.
   always_ff @(posedge clk) begin
      if (srst || tpu_start) begin
         overflow <= 1'b0;
         sat_cnt  <= '0;
      end else if (wr_valid) begin
         if (stall) begin
            overflow <= 1'b1;
         end else begin
            sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
         end
      end
   end

   // FIFO storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr[PTR_W-1:0]] <= st_entry;
      end
   end

   // FIFO pointers with an extra wrap bit to tell full from empty.
   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
   end

   // SRAM write port: strobe follows a pop, address and data hold otherwise.
   always_ff @(posedge clk) begin
      if (srst) begin
         sram_wen   <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
      end else begin
         sram_wen <= pop;
         if (pop) begin
            {sram_addr, sram_wdata} <= fifo_mem[rd_ptr[PTR_W-1:0]];
         end
      end
   end

   // Done FSM state register.
   always_ff @(posedge clk) begin
      if (srst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Done FSM next state: wait until nothing is left in the stage, FIFO or pop path.
   always_comb begin
      state_next = state;
      if (tpu_start) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (tpu_done) state_next = ST_PEND;
            ST_PEND: if (!st_valid && fifo_empty && !pop) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // Done FSM output: one-cycle pulse while in DONE.
   always_comb begin
      wb_done = (state == ST_DONE);
   end

endmodule
